// File: rtl/fetch_decode_pkg.sv
// Shared ISA definitions: FSM state encoding and the opcode/ext constants
// that both the sequencer and the datapath decode against.
package fetch_decode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DECODE  = 2'd2,
    ST_EXECUTE = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] EXT_NOP  = 4'h0;
  localparam logic [3:0] EXT_ADDC = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam int CARRY_BIT = 3;

endpackage

// File: rtl/fetch_decode_dec4to16.sv
// 4-to-16 one-hot decoder with enable; shared with the register bank.
module dec4to16 (
  input  logic        en,
  input  logic [3:0]  sel,
  output logic [15:0] onehot
);

  always_comb begin
    onehot = 16'h0000;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/fetch_decode.sv
// Three-cycle fetch/decode/execute sequencer: drives the instruction
// address, latches the instruction word and issues register write enables.
module fetch_decode
  import fetch_decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic [4:0]  flags,
  output logic [15:0] alu_code,
  output logic [15:0] reg_en,
  output logic        cin,
  output logic        halted,
  output logic [1:0]  state
);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        halted_q, halted_d;

  logic [3:0]  opcode, ext, dest;
  logic        is_nop, is_halt, is_addc;
  logic        wr_en;
  logic        unused_flags;

  assign opcode  = ir_q[15:12];
  assign dest    = ir_q[11:8];
  assign ext     = ir_q[7:4];
  assign is_nop  = (opcode == OP_NOP) && (ext == EXT_NOP);
  assign is_halt = (opcode == OP_HALT);
  assign is_addc = (opcode == OP_NOP) && (ext == EXT_ADDC);

  assign unused_flags = ^{flags[4], flags[2:0]};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a started instruction always runs through EXECUTE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (run && !halted_q) state_d = ST_FETCH;
      ST_FETCH:   state_d = ST_DECODE;
      ST_DECODE:  state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        if (is_halt)  state_d = ST_IDLE;
        else if (run) state_d = ST_FETCH;
        else          state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Program counter, instruction register and halt flag
  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    halted_d = halted_q;
    if (state_q == ST_DECODE) ir_d = mem_data;
    if (state_q == ST_EXECUTE) begin
      if (is_halt) halted_d = 1'b1;
      else         pc_d     = pc_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= 16'h0000;
      ir_q     <= 16'h0000;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
    end
  end

  // Outputs decoded from the current state
  always_comb begin
    wr_en = 1'b0;
    cin   = 1'b0;
    if (state_q == ST_EXECUTE) begin
      wr_en = !is_nop && !is_halt;
      if (is_addc) cin = flags[CARRY_BIT];
    end
  end

  dec4to16 u_dec (
    .en     (wr_en),
    .sel    (dest),
    .onehot (reg_en)
  );

  assign mem_addr = pc_q;
  assign alu_code = ir_q;
  assign halted   = halted_q;
  assign state    = state_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode with a synchronous instruction memory model.
module tb_fetch_decode;

  logic        clk;
  logic        reset;
  logic        run;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic [4:0]  flags;
  logic [15:0] alu_code;
  logic [15:0] reg_en;
  logic        cin;
  logic        halted;
  logic [1:0]  state;

  logic [15:0] mem [0:255];
  int errors = 0;
  int checks = 0;

  fetch_decode dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .flags    (flags),
    .alu_code (alu_code),
    .reg_en   (reg_en),
    .cin      (cin),
    .halted   (halted),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= mem[mem_addr[7:0]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  // One reset edge, then release; the DUT is in IDLE afterwards
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    flags = 5'b00000;
    mem_data = 16'h0000;
    clear_mem();

    // Reset state
    tick();
    tick();
    chk("rst_state",    {14'd0, state}, 16'd0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_alu_code", alu_code, 16'h0000);
    chk("rst_reg_en",   reg_en, 16'h0000);
    chk("rst_cin",      {15'd0, cin}, 16'd0);
    chk("rst_halted",   {15'd0, halted}, 16'd0);

    // Single instruction 0151
    mem[0] = 16'h0151;
    reset = 1'b0;
    run   = 1'b1;
    tick();
    chk("a_fetch_state", {14'd0, state}, 16'd1);
    chk("a_fetch_addr",  mem_addr, 16'h0000);
    tick();
    chk("a_decode_state", {14'd0, state}, 16'd2);
    chk("a_decode_reg_en", reg_en, 16'h0000);
    tick();
    chk("a_exec_state",  {14'd0, state}, 16'd3);
    chk("a_exec_alu",    alu_code, 16'h0151);
    chk("a_exec_reg_en", reg_en, 16'h0002);
    tick();
    chk("a_next_addr",   mem_addr, 16'h0001);
    chk("a_next_reg_en", reg_en, 16'h0000);
    chk("a_next_state",  {14'd0, state}, 16'd1);

    // Write, NOP, HALT
    clear_mem();
    mem[0] = 16'h0251;
    mem[1] = 16'h0000;
    mem[2] = 16'hF000;
    do_reset();
    tick(); tick(); tick();
    chk("b_exec0_reg_en", reg_en, 16'h0004);
    tick(); tick(); tick();
    chk("b_exec1_state",  {14'd0, state}, 16'd3);
    chk("b_exec1_nop",    reg_en, 16'h0000);
    tick(); tick(); tick();
    chk("b_exec2_state",  {14'd0, state}, 16'd3);
    chk("b_exec2_alu",    alu_code, 16'hF000);
    chk("b_exec2_halt",   reg_en, 16'h0000);
    tick();
    chk("b_halted",       {15'd0, halted}, 16'd1);
    chk("b_halt_state",   {14'd0, state}, 16'd0);
    chk("b_halt_addr",    mem_addr, 16'h0002);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("b_hold_state",  {14'd0, state}, 16'd0);
      chk("b_hold_reg_en", reg_en, 16'h0000);
      chk("b_hold_addr",   mem_addr, 16'h0002);
      chk("b_hold_halted", {15'd0, halted}, 16'd1);
    end
    do_reset();
    chk("b_halt_cleared", {15'd0, halted}, 16'd0);

    // ADDC carry-in, then non-ADDC with carry flag set
    clear_mem();
    mem[0] = 16'h0172;
    mem[1] = 16'h0151;
    flags  = 5'b01000;
    do_reset();
    tick();
    chk("c_fetch_cin", {15'd0, cin}, 16'd0);
    tick();
    chk("c_decode_cin", {15'd0, cin}, 16'd0);
    tick();
    chk("c_addc_cin1",   {15'd0, cin}, 16'd1);
    chk("c_addc_reg_en", reg_en, 16'h0002);
    tick();
    chk("c_cin_not_sticky", {15'd0, cin}, 16'd0);
    tick(); tick();
    chk("c_add_alu", alu_code, 16'h0151);
    chk("c_add_cin", {15'd0, cin}, 16'd0);
    flags = 5'b10111;
    do_reset();
    tick(); tick(); tick();
    chk("c_addc_cin0",  alu_code, 16'h0172);
    chk("c_addc_flag0", {15'd0, cin}, 16'd0);
    flags = 5'b00000;

    // Reset during DECODE
    clear_mem();
    mem[0] = 16'h0151;
    do_reset();
    tick(); tick();
    chk("d_in_decode", {14'd0, state}, 16'd2);
    reset = 1'b1;
    run   = 1'b0;
    tick();
    reset = 1'b0;
    chk("d_state",    {14'd0, state}, 16'd0);
    chk("d_mem_addr", mem_addr, 16'h0000);
    chk("d_reg_en",   reg_en, 16'h0000);
    chk("d_alu_code", alu_code, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("d_no_pulse", reg_en, 16'h0000);
    end

    // run dropped during FETCH of addr 1, then resumed
    clear_mem();
    mem[0] = 16'h0151;
    mem[1] = 16'h0352;
    mem[2] = 16'h0451;
    run = 1'b1;
    do_reset();
    tick(); tick(); tick();
    chk("e_exec0_reg_en", reg_en, 16'h0002);
    tick();
    chk("e_fetch1_state", {14'd0, state}, 16'd1);
    chk("e_fetch1_addr",  mem_addr, 16'h0001);
    run = 1'b0;
    tick();
    chk("e_decode1_state", {14'd0, state}, 16'd2);
    tick();
    chk("e_exec1_state",  {14'd0, state}, 16'd3);
    chk("e_exec1_reg_en", reg_en, 16'h0008);
    tick();
    chk("e_stop_state",   {14'd0, state}, 16'd0);
    chk("e_stop_addr",    mem_addr, 16'h0002);
    chk("e_stop_reg_en",  reg_en, 16'h0000);
    tick();
    chk("e_idle_hold",    {14'd0, state}, 16'd0);
    run = 1'b1;
    tick();
    chk("e_resume_state", {14'd0, state}, 16'd1);
    chk("e_resume_addr",  mem_addr, 16'h0002);
    tick(); tick();
    chk("e_exec2_alu",    alu_code, 16'h0451);
    chk("e_exec2_reg_en", reg_en, 16'h0010);
    tick();
    chk("e_after_addr",   mem_addr, 16'h0003);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
